axi_wr_arbiter: RTL and testbench

// - Round-robin arbiter and transaction sequencer for the 3-master AXI write-channel mux.
// - Drives the one-hot wr_grant select into the write mux.
// - Holds each grant from AW acceptance through the B handshake.
// - Checks W burst length against awlen and releases stalled transactions on timeout.

---
 rtl/axi_wr_arbiter_pkg.sv | 20 ++
 rtl/axi_wr_arbiter_rr_pick3.sv | 40 ++++
 rtl/axi_wr_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter_pkg
// Shared definitions for the AXI interconnect arbiters (write side and read
// side): sequencer state encodings and one-hot grant constants.
// No ports; imported with "import axi_wr_arbiter_pkg::*;".
// ---------------------------------------------------------------------------
package axi_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_M0   = 3'b001;
  localparam logic [2:0] GNT_M1   = 3'b010;
  localparam logic [2:0] GNT_M2   = 3'b100;

endpackage : axi_wr_arbiter_pkg

// File: rtl/axi_wr_arbiter_rr_pick3.sv
// ---------------------------------------------------------------------------
// axi_rr_pick3
// Combinational 3-way round-robin picker. Returns the first requester after
// the previously granted master, scanning m0 -> m1 -> m2 -> m0.
// Ports:
//   req  [2:0] in   request vector {m2,m1,m0}
//   last [2:0] in   one-hot previous grant; anything not one-hot acts as m2
//   pick [2:0] out  one-hot winner, 3'b000 when nothing requests
// ---------------------------------------------------------------------------
module axi_rr_pick3
  import axi_wr_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] last,
  output logic [2:0] pick
);

  always_comb begin
    pick = GNT_NONE;
    case (last)
      GNT_M0: begin
        if (req[1])      pick = GNT_M1;
        else if (req[2]) pick = GNT_M2;
        else if (req[0]) pick = GNT_M0;
      end
      GNT_M1: begin
        if (req[2])      pick = GNT_M2;
        else if (req[0]) pick = GNT_M0;
        else if (req[1]) pick = GNT_M1;
      end
      // GNT_M2 and the reset value land here, so m0 has first priority.
      default: begin
        if (req[0])      pick = GNT_M0;
        else if (req[1]) pick = GNT_M1;
        else if (req[2]) pick = GNT_M2;
      end
    endcase
  end

endmodule : axi_rr_pick3

// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
// Round-robin arbiter and transaction sequencer for a 3-master AXI write
// channel mux. A grant is held from AW acceptance through the B handshake;
// the W burst length is checked against awlen and a watchdog releases
// stalled transactions.
// Parameters:
//   TIMEOUT_CYCLES  handshake-free cycles before forced release (0 = off)
//   TO_WIDTH        watchdog counter width, 2**TO_WIDTH > TIMEOUT_CYCLES
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   m_awvalid[2:0]          raw awvalid of masters {m2,m1,m0}
//   s_awvalid, s_awlen      muxed AW valid / length
//   m_awready               slave awready
//   s_wvalid, s_wlast       muxed W valid / last
//   m_wready                slave wready
//   m_bvalid, s_bready      slave bvalid, muxed bready
//   wr_grant[2:0]           registered one-hot mux select
//   busy                    sequencer not idle
//   len_err                 1-cycle pulse: beat count != awlen+1
//   timeout_err             1-cycle pulse: watchdog forced release
// ---------------------------------------------------------------------------
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = 11
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [2:0] m_awvalid,
  input  logic       s_awvalid,
  input  logic [7:0] s_awlen,
  input  logic       m_awready,
  input  logic       s_wvalid,
  input  logic       s_wlast,
  input  logic       m_wready,
  input  logic       m_bvalid,
  input  logic       s_bready,
  output logic [2:0] wr_grant,
  output logic       busy,
  output logic       len_err,
  output logic       timeout_err
);

  localparam bit                WD_ENABLE = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_e          state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [2:0]          last_grant_q, last_grant_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                w_extra_q, w_extra_d;
  logic [8:0]          beat_cnt_q, beat_cnt_d;
  logic [8:0]          final_cnt_q, final_cnt_d;
  logic [7:0]          len_q, len_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;

  logic       aw_hs, w_hs, b_hs, any_hs;
  logic       wd_fire;
  logic [2:0] pick;

  // Locals of the next-state process, given defaults on entry.
  logic       aw_now, aw_set, w_set, extra_eff;
  logic [7:0] len_eff;
  logic [8:0] cnt_eff;

  assign aw_hs  = s_awvalid & m_awready;
  assign w_hs   = s_wvalid & m_wready;
  assign b_hs   = m_bvalid & s_bready;
  assign any_hs = aw_hs | w_hs | b_hs;

  // Terminal count with no handshake this cycle. A handshake landing on the
  // terminal cycle (notably b_hs) keeps the transaction alive.
  assign wd_fire = WD_ENABLE && (to_cnt_q == TO_LAST) && !any_hs;

  axi_rr_pick3 u_pick (
    .req  (m_awvalid),
    .last (last_grant_q),
    .pick (pick)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    w_extra_d    = w_extra_q;
    beat_cnt_d   = beat_cnt_q;
    final_cnt_d  = final_cnt_q;
    len_d        = len_q;
    to_cnt_d     = to_cnt_q;
    len_err      = 1'b0;
    timeout_err  = 1'b0;
    aw_now       = 1'b0;
    aw_set       = 1'b0;
    w_set        = 1'b0;
    extra_eff    = 1'b0;
    len_eff      = len_q;
    cnt_eff      = final_cnt_q;

    // Watchdog runs only while a master holds the bus.
    if (state_q != ST_IDLE) begin
      if (any_hs || !WD_ENABLE) to_cnt_d = '0;
      else                      to_cnt_d = to_cnt_q + TO_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (m_awvalid != 3'b000) begin
          grant_d    = pick;
          state_d    = ST_XFER;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          w_extra_d  = 1'b0;
          beat_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end

      ST_XFER: begin
        // Only the first AW handshake of a grant defines the burst.
        aw_now = aw_hs & ~aw_done_q;
        if (aw_now) begin
          len_d     = s_awlen;
          aw_done_d = 1'b1;
        end

        if (w_hs) begin
          if (w_done_q) begin
            // Beats past wlast are not counted but poison the length check.
            w_extra_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
            if (s_wlast) begin
              w_done_d    = 1'b1;
              final_cnt_d = beat_cnt_q + 9'd1;
            end
          end
        end

        // Use this cycle's handshake values where the registers are not yet
        // loaded, so the check works whichever channel finishes last.
        aw_set    = aw_done_q | aw_now;
        w_set     = w_done_q | (w_hs & s_wlast);
        len_eff   = aw_done_q ? len_q : s_awlen;
        cnt_eff   = w_done_q ? final_cnt_q : (beat_cnt_q + 9'd1);
        extra_eff = w_extra_q | (w_hs & w_done_q);

        if (aw_set && w_set) begin
          // Reaching here needs a handshake this cycle, so the watchdog
          // cannot fire alongside len_err.
          state_d = ST_RESP;
          len_err = extra_eff || (cnt_eff != ({1'b0, len_eff} + 9'd1));
        end else if (wd_fire) begin
          timeout_err  = 1'b1;
          grant_d      = GNT_NONE;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end

      ST_RESP: begin
        if (b_hs) begin
          grant_d      = GNT_NONE;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else if (wd_fire) begin
          timeout_err  = 1'b1;
          grant_d      = GNT_NONE;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_NONE;
      last_grant_q <= GNT_M2;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      w_extra_q    <= 1'b0;
      beat_cnt_q   <= '0;
      final_cnt_q  <= '0;
      len_q        <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      w_extra_q    <= w_extra_d;
      beat_cnt_q   <= beat_cnt_d;
      final_cnt_q  <= final_cnt_d;
      len_q        <= len_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign wr_grant = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule : axi_wr_arbiter

// File: tb/tb_axi_wr_arbiter.sv
module tb_axi_wr_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [2:0] m_awvalid;
  logic       s_awvalid;
  logic [7:0] s_awlen;
  logic       m_awready;
  logic       s_wvalid;
  logic       s_wlast;
  logic       m_wready;
  logic       m_bvalid;
  logic       s_bready;
  logic [2:0] wr_grant;
  logic       busy;
  logic       len_err;
  logic       timeout_err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model state: index of the last granted master (m2 after reset).
  int last_idx = 2;

  axi_wr_arbiter #(
    .TIMEOUT_CYCLES (16),
    .TO_WIDTH       (5)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .m_awvalid   (m_awvalid),
    .s_awvalid   (s_awvalid),
    .s_awlen     (s_awlen),
    .m_awready   (m_awready),
    .s_wvalid    (s_wvalid),
    .s_wlast     (s_wlast),
    .m_wready    (m_wready),
    .m_bvalid    (m_bvalid),
    .s_bready    (s_bready),
    .wr_grant    (wr_grant),
    .busy        (busy),
    .len_err     (len_err),
    .timeout_err (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round robin: first requester strictly after the last winner, cyclically.
  function automatic logic [2:0] model_pick(input logic [2:0] req);
    int i;
    for (int k = 1; k <= 3; k++) begin
      i = (last_idx + k) % 3;
      if (req[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  function automatic int idx_of(input logic [2:0] oh);
    return oh[0] ? 0 : (oh[1] ? 1 : 2);
  endfunction

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_bus();
    s_awvalid = 1'b0; m_awready = 1'b0; s_awlen = 8'd0;
    s_wvalid  = 1'b0; s_wlast   = 1'b0; m_wready = 1'b0;
    m_bvalid  = 1'b0; s_bready  = 1'b0;
  endtask

  // One transaction. Entered at posedge+1 of an IDLE cycle; leaves at
  // posedge+1 of the IDLE cycle following the B handshake.
  // aw_step: AW accepted together with W beat aw_step, or alone after all
  // beats when aw_step == nb.
  task automatic do_txn(input logic [2:0] req, input logic [7:0] awlen, input int nb,
                        input int aw_step, input int bdly, output logic [2:0] got);
    logic [2:0] exp_g;
    int         done_step;
    logic       exp_len_err;
    exp_g       = model_pick(req);
    exp_len_err = (nb != int'(awlen) + 1);
    done_step   = (aw_step >= nb) ? nb : nb - 1;
    clr_bus();
    m_awvalid = req;
    #1;
    chk("idle_grant", wr_grant, 3'b000);
    chk("idle_busy", busy, 1'b0);
    cyc();
    got = wr_grant;
    for (int s = 0; s <= done_step; s++) begin
      clr_bus();
      if (s < nb) begin
        s_wvalid = 1'b1; m_wready = 1'b1; s_wlast = (s == nb - 1);
      end
      if (s == aw_step) begin
        s_awvalid = 1'b1; m_awready = 1'b1; s_awlen = awlen;
      end
      #1;
      chk("xfer_grant", wr_grant, exp_g);
      chk("xfer_busy", busy, 1'b1);
      chk("len_err", len_err, (s == done_step) ? exp_len_err : 1'b0);
      chk("xfer_to", timeout_err, 1'b0);
      cyc();
    end
    for (int d = 0; d < bdly; d++) begin
      clr_bus();
      #1;
      chk("resp_grant", wr_grant, exp_g);
      chk("resp_len_err", len_err, 1'b0);
      cyc();
    end
    clr_bus();
    m_awvalid = 3'b000;
    m_bvalid = 1'b1; s_bready = 1'b1;
    #1;
    chk("bhs_grant", wr_grant, exp_g);
    chk("bhs_to", timeout_err, 1'b0);
    cyc();
    clr_bus();
    last_idx = idx_of(exp_g);
    $display("txn req=%b awlen=%0d beats=%0d aw_step=%0d bdly=%0d grant=%b exp=%b",
             req, awlen, nb, aw_step, bdly, got, exp_g);
  endtask

  initial begin
    logic [2:0] got;
    logic [2:0] rr_seq [4];
    int nb, aws;
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;

    sys_rst   = 1'b1;
    m_awvalid = 3'b000;
    clr_bus();
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    #1;
    chk("rst_grant", wr_grant, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_to", timeout_err, 1'b0);
    cyc();

    // All masters requesting: strict rotation starting at m0.
    for (int t = 0; t < 4; t++) begin
      do_txn(3'b111, 8'd0, 1, 0, 0, got);
      chk("rr_seq", got, rr_seq[t]);
    end

    // m1 alone, awlen=3, 4 beats, B after a short wait.
    do_txn(3'b010, 8'd3, 4, 0, 2, got);
    chk("m1_grant", got, 3'b010);

    // m0: W burst fully ahead of AW.
    do_txn(3'b001, 8'd1, 2, 2, 1, got);
    chk("m0_wfirst", got, 3'b001);

    // Short burst: awlen=3 but wlast on beat 2.
    do_txn(3'b100, 8'd3, 2, 0, 0, got);
    chk("short_grant", got, 3'b100);

    // Randomized transactions against the model.
    for (int t = 0; t < 24; t++) begin
      nb  = $urandom_range(1, 4);
      aws = $urandom_range(0, nb);
      do_txn(3'($urandom_range(1, 7)), 8'($urandom_range(0, 4)), nb, aws,
             $urandom_range(0, 3), got);
    end

    // Watchdog: m0 finishes AW/W, B never comes; m2 waits.
    clr_bus();
    m_awvalid = 3'b001;
    #1;
    chk("wd_idle", wr_grant, 3'b000);
    cyc();
    m_awvalid = 3'b100;
    s_awvalid = 1'b1; m_awready = 1'b1; s_awlen = 8'd0;
    s_wvalid = 1'b1; m_wready = 1'b1; s_wlast = 1'b1;
    #1;
    chk("wd_grant", wr_grant, 3'b001);
    chk("wd_len_err", len_err, 1'b0);
    cyc();
    for (int j = 1; j <= 16; j++) begin
      clr_bus();
      #1;
      chk("wd_to", timeout_err, (j == 16) ? 1'b1 : 1'b0);
      chk("wd_hold", wr_grant, 3'b001);
      chk("wd_len_err", len_err, 1'b0);
      cyc();
    end
    last_idx = 0;
    #1;
    chk("wd_release", wr_grant, 3'b000);
    chk("wd_busy", busy, 1'b0);
    chk("wd_to_pulse", timeout_err, 1'b0);
    $display("timeout released m0 after 16 idle cycles");
    cyc();
    #1;
    chk("wd_next", wr_grant, model_pick(3'b100));
    $display("pending m2 granted grant=%b", wr_grant);

    // Asynchronous reset in the middle of that transaction.
    sys_rst = 1'b1;
    #1;
    chk("arst_grant", wr_grant, 3'b000);
    chk("arst_busy", busy, 1'b0);
    m_awvalid = 3'b000;
    cyc();
    sys_rst  = 1'b0;
    last_idx = 2;
    cyc();
    chk("post_rst", wr_grant, 3'b000);
    $display("async reset cleared grant mid-transaction");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish observed=running expected=done");
    $fatal(1, "time limit");
  end

endmodule : tb_axi_wr_arbiter
